cke_sched: RTL and testbench
============================

CKE_SCHED -- requirements
Module: cke_sched

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of clock-enable channels (1..16).
REQ-002 SHALL have parameter W, default 26: period register width in bits.
REQ-003 SHALL have parameter DEFAULT_T, default 50000000: period loaded into every channel at reset; must fit in W bits.
REQ-004 SHALL have parameter RST_EN, default N_CH'b1: per-channel enable value at reset.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port ena  input  1  global count enable; low freezes all channel counters and forces cke low.
REQ-008 SHALL have port cfg_valid  input  1  configuration request valid.
REQ-009 SHALL have port cfg_ready  output  1  scheduler can accept a configuration this cycle.
REQ-010 SHALL have port cfg_ch  input  $clog2(N_CH) (min 1)  target channel index.
REQ-011 SHALL have port cfg_period  input  W  new period in clk cycles.
REQ-012 SHALL have port cfg_en  input  1  new channel enable.
REQ-013 SHALL have port sync_req  input  1  request to realign (clear) all channel counters.
REQ-014 SHALL have port busy  output  1  scheduler is in a non-IDLE state.
REQ-015 SHALL have port cke  output  N_CH  per-channel clock-enable strobes.

Function
REQ-016 SHALL hold per channel i: period_r[i] (W bits), cnt[i] (W bits), en_r[i] (1 bit).
REQ-017 SHALL implement states IDLE, APPLY, SYNC; busy = (state != IDLE).
REQ-018 SHALL drive cfg_ready = (state == IDLE) && !sync_req.
REQ-019 IDLE: sync_req high -> SYNC (priority over cfg_valid); else cfg_valid && cfg_ready -> APPLY, latching cfg_ch/cfg_period/cfg_en in the same edge; else stay.
REQ-020 APPLY lasts exactly one cycle; at its closing edge the target channel gets period_r = latched period, cnt = 0, en_r = latched enable; next state IDLE.
REQ-021 SYNC lasts exactly one cycle; at its closing edge every cnt[i] = 0; period_r and en_r unchanged; next state IDLE.
REQ-022 Outside the APPLY/SYNC closing edges, cnt[i] SHALL advance only when ena && en_r[i] && period_r[i] != 0: cnt = (cnt == period_r-1) ? 0 : cnt+1.
REQ-023 SHALL decode cke[i] combinationally from registers: en_r[i] && ena && period_r[i] != 0 && cnt[i] == period_r[i]-1.
REQ-024 Period 1 SHALL yield cke[i] high every cycle ena is high; period P>=2 yields one-cycle pulse every P enabled cycles.
REQ-025 Period 0 SHALL be treated as disabled: cke[i] low, cnt[i] frozen, regardless of en_r[i].
REQ-026 cfg_ch >= N_CH SHALL still be accepted and pass through APPLY but modify no channel.
REQ-027 Channels not targeted by APPLY SHALL keep counting undisturbed during APPLY and SYNC cycles except as stated in REQ-021.
REQ-028 Latency: handshake at edge k -> APPLY during cycle k+1 -> new cnt=0 visible cycle k+2; first cke of period P during cycle k+2+P-1 (ena held high).
REQ-029 cfg_valid without cfg_ready SHALL have no effect; the requester holds its request until accepted.
REQ-030 All counter arithmetic SHALL be W-bit unsigned; no overflow beyond period_r-1 is reachable.

Reset
REQ-031 rst high at a rising edge SHALL force state IDLE, every cnt = 0, period_r = DEFAULT_T, en_r = RST_EN, and discard any latched config, overriding any in-progress APPLY/SYNC.
REQ-032 During and after reset: busy = 0, cke = 0 while cnt = 0 unless period is 1; cfg_ready = !sync_req in the first cycle after reset.

Verification
REQ-033 Reset with N_CH=4, DEFAULT_T=4, ena=1 -> cke[0] pulses on cycles 4,8,12 after reset release; cke[3:1] stay 0.
REQ-034 Write ch2 period 3 en 1 in IDLE -> cfg_ready low 1 cycle, busy high 1 cycle, cke[2] first high 3 cycles after APPLY, then every 3rd cycle.
REQ-035 sync_req and cfg_valid asserted together in IDLE -> SYNC taken, cfg not accepted; all cnt = 0 next cycle; cfg accepted on the following cycle once sync_req drops.
REQ-036 ch1 period 1 then ena toggled 1,0,1 -> cke[1] = 1,0,1; period 0 written -> cke[1] stays 0 with ena high.
REQ-037 rst asserted during APPLY for ch2 -> ch2 keeps DEFAULT_T and en_r[2]=RST_EN[2]; state IDLE next cycle.
REQ-038 cfg_ch=5 with N_CH=4 -> one APPLY cycle, all channel registers and cke pattern unchanged.

Source files
------------

// File: rtl/cke_sched.sv
// cke_sched: per-channel clock-enable strobe generator with handshake reconfiguration
// and a global counter realign.
module cke_sched #(
    parameter int N_CH = 4,
    parameter int W = 26,
    parameter int DEFAULT_T = 50000000,
    parameter logic [N_CH-1:0] RST_EN = N_CH'(1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ena,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
    input  logic [W-1:0]                           cfg_period,
    input  logic                                   cfg_en,
    input  logic                                   sync_req,
    output logic                                   busy,
    output logic [N_CH-1:0]                        cke
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, SYNC} state_t;

    state_t state, state_nx;
    logic [CW-1:0] ch_l;
    logic [W-1:0] per_l;
    logic en_l;
    logic [W-1:0] period_r [N_CH];
    logic [W-1:0] cnt [N_CH];
    logic [N_CH-1:0] en_r, live;

    assign busy = state != IDLE;
    assign cfg_ready = state == IDLE && !sync_req;

    // APPLY and SYNC are single-cycle; sync_req wins over a pending config
    always_comb state_nx = (state != IDLE) ? IDLE : sync_req ? SYNC : cfg_valid ? APPLY : IDLE;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign live[i] = en_r[i] && ena && period_r[i] != '0;
        assign cke[i] = live[i] && cnt[i] == period_r[i] - W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ch_l <= '0;
            per_l <= '0;
            en_l <= 1'b0;
            en_r <= RST_EN;
            for (int i = 0; i < N_CH; i++) begin
                period_r[i] <= W'(DEFAULT_T);
                cnt[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (state == IDLE && cfg_valid && cfg_ready) begin
                ch_l <= cfg_ch;
                per_l <= cfg_period;
                en_l <= cfg_en;
            end
            // an out-of-range ch_l matches no channel, so APPLY is a no-op then
            for (int i = 0; i < N_CH; i++) begin
                if (state == SYNC) begin
                    cnt[i] <= '0;
                end else if (state == APPLY && ch_l == CW'(i)) begin
                    period_r[i] <= per_l;
                    cnt[i] <= '0;
                    en_r[i] <= en_l;
                end else if (live[i]) begin
                    cnt[i] <= cke[i] ? '0 : cnt[i] + W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_cke_sched.sv
// tb_cke_sched: directed plus random checks of cke_sched against a tick-count reference model.
// A 3-channel instance shares the stimulus so that a 2-bit cfg_ch can address a missing channel.
module tb_cke_sched;
    localparam int W = 8;
    localparam int DT = 4;

    logic clk = 1'b0;
    logic rst, ena, cfg_valid, cfg_en, sync_req;
    logic [1:0] cfg_ch;
    logic [W-1:0] cfg_period;
    logic rdy4, busy4, rdy3, busy3;
    logic [3:0] cke4;
    logic [2:0] cke3;

    always #5 clk = ~clk;

    cke_sched #(.N_CH(4), .W(W), .DEFAULT_T(DT)) u_dut4 (
        .clk(clk), .rst(rst), .ena(ena), .cfg_valid(cfg_valid), .cfg_ready(rdy4),
        .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_en(cfg_en), .sync_req(sync_req),
        .busy(busy4), .cke(cke4)
    );

    cke_sched #(.N_CH(3), .W(W), .DEFAULT_T(DT)) u_dut3 (
        .clk(clk), .rst(rst), .ena(ena), .cfg_valid(cfg_valid), .cfg_ready(rdy3),
        .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_en(cfg_en), .sync_req(sync_req),
        .busy(busy3), .cke(cke3)
    );

    int nchk = 0;
    int nfail = 0;

    // model: m=0 is the 4-channel instance, m=1 the 3-channel one;
    // ticks counts enabled cycles since the channel was last cleared
    int per [2][4];
    int ticks [2][4];
    bit en [2][4];
    int pend;
    int pch, pper;
    bit pen;

    function automatic bit exp_cke(int m, int i);
        return en[m][i] && ena && per[m][i] != 0 && (ticks[m][i] + 1) % per[m][i] == 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            pend = 0;
            for (int m = 0; m < 2; m++)
                for (int i = 0; i < 4; i++) begin
                    per[m][i] = DT;
                    en[m][i] = (i == 0);
                    ticks[m][i] = 0;
                end
        end else begin
            for (int m = 0; m < 2; m++)
                for (int i = 0; i < (m == 0 ? 4 : 3); i++) begin
                    if (pend == 2) ticks[m][i] = 0;
                    else if (pend == 1 && pch == i) begin
                        per[m][i] = pper;
                        en[m][i] = pen;
                        ticks[m][i] = 0;
                    end else if (en[m][i] && ena && per[m][i] != 0) ticks[m][i]++;
                end
            if (pend != 0) pend = 0;
            else if (sync_req) pend = 2;
            else if (cfg_valid) begin
                pend = 1;
                pch = int'(cfg_ch);
                pper = int'(cfg_period);
                pen = cfg_en;
            end
        end
    endtask

    task automatic cyc();
        logic [3:0] e4;
        logic [2:0] e3;
        @(negedge clk);
        for (int i = 0; i < 4; i++) e4[i] = exp_cke(0, i);
        for (int i = 0; i < 3; i++) e3[i] = exp_cke(1, i);
        chk("cke4", 32'(cke4), 32'(e4));
        chk("cke3", 32'(cke3), 32'(e3));
        chk("busy4", 32'(busy4), 32'(pend != 0));
        chk("busy3", 32'(busy3), 32'(pend != 0));
        chk("ready4", 32'(rdy4), 32'(pend == 0 && !sync_req));
        chk("ready3", 32'(rdy3), 32'(pend == 0 && !sync_req));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input int ch, input int p, input bit e);
        cfg_valid = 1'b1;
        cfg_ch = 2'(ch);
        cfg_period = W'(p);
        cfg_en = e;
        cyc();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b0;
        cfg_valid = 1'b0;
        cfg_en = 1'b0;
        sync_req = 1'b0;
        cfg_ch = '0;
        cfg_period = '0;
        @(posedge clk);
        model_step();
        #1;
        cyc();
        rst = 1'b0;
        ena = 1'b1;
        run(13);
        // ch2 period 3
        wr(2, 3, 1'b1);
        run(10);
        // sync collides with a config request
        sync_req = 1'b1;
        cfg_valid = 1'b1;
        cfg_ch = 2'd1;
        cfg_period = W'(1);
        cfg_en = 1'b1;
        cyc();
        sync_req = 1'b0;
        cyc();
        cfg_valid = 1'b0;
        run(3);
        ena = 1'b0;
        cyc();
        ena = 1'b1;
        run(2);
        wr(1, 0, 1'b1);
        run(4);
        // reset lands on the APPLY cycle
        wr(2, 5, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        run(6);
        // channel 3 is absent from the 3-channel instance
        wr(3, 2, 1'b1);
        run(6);
        wr(3, 0, 1'b0);
        run(3);
        for (int k = 0; k < 600; k++) begin
            rst = $urandom_range(0, 99) == 0;
            ena = $urandom_range(0, 9) != 0;
            sync_req = $urandom_range(0, 7) == 0;
            cfg_valid = $urandom_range(0, 2) == 0;
            cfg_ch = 2'($urandom);
            cfg_period = W'($urandom_range(0, 6));
            cfg_en = $urandom_range(0, 3) != 0;
            cyc();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
